// File: rtl/btn_irq_conditioner.sv
`default_nettype none
// btn_irq_conditioner: per-channel synchroniser + debounce FSM, press/release pulses,
// sticky maskable interrupt-pending bits.  Rev 1.0
module btn_irq_conditioner #(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_btn,
  input  logic [N_CH-1:0] i_edge_sel,
  input  logic [N_CH-1:0] i_irq_mask,
  input  logic [N_CH-1:0] i_pend_clr,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_pending,
  output logic            o_irq
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [1:0] ST_REL   = 2'd0;
  localparam logic [1:0] ST_W_PRS = 2'd1;
  localparam logic [1:0] ST_PRS   = 2'd2;
  localparam logic [1:0] ST_W_REL = 2'd3;

  logic [N_CH-1:0] s_in;
  assign s_in = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

  genvar ch;
  generate
    for (ch = 0; ch < N_CH; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [1:0]             state_q, state_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   press_q, press_d;
      logic                   rel_q, rel_d;
      logic                   pend_q, pend_d;
      logic                   s;

      assign s = sync_q[SYNC_STAGES-1];

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
          ST_REL: begin
            if (s) begin
              state_d = ST_W_PRS;
              cnt_d   = CW'(1);
            end
          end
          ST_W_PRS: begin
            if (!s) begin
              state_d = ST_REL;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_PRS;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          ST_PRS: begin
            if (!s) begin
              state_d = ST_W_REL;
              cnt_d   = CW'(1);
            end
          end
          ST_W_REL: begin
            if (s) begin
              state_d = ST_PRS;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_REL;
              cnt_d   = '0;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = ST_REL;
            cnt_d   = '0;
          end
        endcase

        // A new event takes priority over a simultaneous clear strobe.
        if (press_d || (i_edge_sel[ch] && rel_d)) begin
          pend_d = 1'b1;
        end else if (i_pend_clr[ch]) begin
          pend_d = 1'b0;
        end else begin
          pend_d = pend_q;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sync_q  <= '0;
          state_q <= ST_REL;
          cnt_q   <= '0;
          level_q <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          pend_q  <= 1'b0;
        end else begin
          sync_q  <= {sync_q[SYNC_STAGES-2:0], s_in[ch]};
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          press_q <= press_d;
          rel_q   <= rel_d;
          pend_q  <= pend_d;
        end
      end

      assign o_level[ch]   = level_q;
      assign o_press[ch]   = press_q;
      assign o_release[ch] = rel_q;
      assign o_pending[ch] = pend_q;
    end
  endgenerate

  assign o_irq = |(o_pending & i_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_btn_irq_conditioner.sv
`default_nettype none
// tb_btn_irq_conditioner: directed table + hand sequences for the button conditioner.
// Rev 1.0
module tb_btn_irq_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn, esel, mask, clr;
  logic [3:0] level, press, rel, pending;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] pend;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  btn_irq_conditioner #(
    .N_CH(4), .DB_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_edge_sel(esel),
    .i_irq_mask(mask), .i_pend_clr(clr), .o_level(level), .o_press(press),
    .o_release(rel), .o_pending(pending), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string name, input logic [3:0] el, input logic [3:0] ep,
                     input logic [3:0] er, input logic [3:0] epd, input logic ei);
    logic [16:0] act, exp;
    act = {level, press, rel, pending, irq};
    exp = {el, ep, er, epd, ei};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lvl=%b prs=%b rel=%b pend=%b irq=%b, want lvl=%b prs=%b rel=%b pend=%b irq=%b",
               name, level, press, rel, pending, irq, el, ep, er, epd, ei);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p,
                              input logic [3:0] pd, input logic i);
    vec_t v;
    v.btn = b; v.level = l; v.press = p; v.pend = pd; v.irq = i;
    return v;
  endfunction

  initial begin
    // ch0 press: pulse, level, pending and irq all appear on the 6th edge
    for (int r = 1; r <= 5; r++) tbl.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b1110, 4'b0001, 4'b0001, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b1110, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    // ch1 bounce: 3 low / 2 high, five times, never accepted
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) tbl.push_back(mk(4'b1100, 4'b0001, 4'b0000, 4'b0001, 1'b1));
      for (int k = 0; k < 2; k++) tbl.push_back(mk(4'b1110, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    end
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b1110, 4'b0001, 4'b0000, 4'b0001, 1'b1));

    rst = 1'b1; btn = 4'b1111; esel = 4'b0000; mask = 4'b0001; clr = 4'b0000;
    @(negedge clk);
    ticks(2);
    chk("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      btn = tbl[i].btn;
      tick();
      chk($sformatf("row%0d", i), tbl[i].level, tbl[i].press, 4'b0000, tbl[i].pend, tbl[i].irq);
    end

    // ch2 press, clear, release without release-pending
    btn = 4'b1010;
    ticks(5);
    chk("ch2_press_early", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    tick();
    chk("ch2_press", 4'b0101, 4'b0100, 4'b0000, 4'b0101, 1'b1);
    clr = 4'b0100; tick(); clr = 4'b0000;
    chk("ch2_clr", 4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    btn = 4'b1110;
    ticks(5);
    chk("ch2_rel_early", 4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    tick();
    chk("ch2_rel_nosel", 4'b0001, 4'b0000, 4'b0100, 4'b0001, 1'b1);
    tick();
    chk("ch2_rel_pulse_end", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);

    // ch2 again, release with edge_sel set
    btn = 4'b1010;
    ticks(6);
    chk("ch2_press2", 4'b0101, 4'b0100, 4'b0000, 4'b0101, 1'b1);
    clr = 4'b0100; tick(); clr = 4'b0000;
    esel = 4'b0100;
    btn = 4'b1110;
    ticks(6);
    chk("ch2_rel_sel", 4'b0001, 4'b0000, 4'b0100, 4'b0101, 1'b1);

    // mask gating, combinational response
    clr = 4'b0001; tick(); clr = 4'b0000;
    chk("mask_gates", 4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    mask = 4'b0101; #1;
    chk("mask_raise", 4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    mask = 4'b0001; #1;
    chk("mask_drop", 4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    clr = 4'b0100; @(negedge clk); tick(); clr = 4'b0000;
    chk("ch2_clr_all", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // ch0 release then press with clear on the same edge
    btn = 4'b1111;
    ticks(6);
    chk("ch0_rel", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    btn = 4'b1110;
    ticks(5);
    clr = 4'b0001; tick();
    chk("set_wins", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    tick(); clr = 4'b0000;
    chk("clr_alone", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // reset while ch3 sits at cnt=2 in W_PRS
    btn = 4'b0110;
    ticks(4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("reset_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    ticks(5);
    chk("post_reset_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    chk("post_reset_press", 4'b1001, 4'b1001, 4'b0000, 4'b1001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
